// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and defaults for the interrupt sequencer
package irq_pkg;

  localparam int NSRC_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
module irq_prio_enc #(
  parameter int NSRC = irq_pkg::NSRC_DEFAULT,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] vec,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the last hit, the lowest index, is what remains.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-detecting, masked, single-level interrupt sequencer
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEFAULT,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            ExtlAck,
  input  logic            irq_done,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  cause_id,
  output logic [NSRC-1:0] pending,
  output logic            busy
);

  irq_state_t      state_q, state_d;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] irq_event;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pending_d;
  logic [IDW-1:0]  winner;
  logic            winner_valid;
  logic [IDW-1:0]  cause_d;
  logic            ext_irq_d;
  logic            ack_fire;

  assign irq_event = irq_src & ~src_q;
  assign eligible  = pending & ~irq_mask;

  irq_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio_enc (
    .vec   (eligible),
    .idx   (winner),
    .valid (winner_valid)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_id;
    ext_irq_d = ExtIRQ;
    ack_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner_valid) begin
          cause_d   = winner;
          ext_irq_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // cause_id is frozen here; later arrivals wait for the next IDLE.
        if (ExtlAck) begin
          ack_fire  = 1'b1;
          ext_irq_d = 1'b0;
          state_d   = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        ext_irq_d = 1'b0;
      end
    endcase
  end

  // A fresh edge on the acked source re-sets its bit in the same cycle.
  assign clr       = ack_fire ? (NSRC'(1) << cause_id) : '0;
  assign pending_d = (pending & ~clr) | irq_event;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      pending  <= '0;
      cause_id <= '0;
      ExtIRQ   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= irq_src;
      pending  <= pending_d;
      cause_id <= cause_d;
      ExtIRQ   <= ext_irq_d;
    end
  end

  assign busy = (state_q == REQ) || (state_q == SERVICE);

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller
module tb_irq_controller;

  localparam int NSRC = 4;
  localparam int IDW  = 2;

  logic            clk;
  logic            rst_n;
  logic [NSRC-1:0] irq_src;
  logic [NSRC-1:0] irq_mask;
  logic            ext_ack;
  logic            irq_done;
  logic            ext_irq;
  logic [IDW-1:0]  cause_id;
  logic [NSRC-1:0] pending;
  logic            busy;

  int n_pass;
  int n_total;
  int exp_q[$];

  irq_controller #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .irq_src  (irq_src),
    .irq_mask (irq_mask),
    .ExtlAck  (ext_ack),
    .irq_done (irq_done),
    .ExtIRQ   (ext_irq),
    .cause_id (cause_id),
    .pending  (pending),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the request now on the bus against the oldest expected cause.
  task automatic expect_req(input string tag);
    int exp_id;
    check({tag, "_irq"}, 32'(ext_irq), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      exp_id = exp_q.pop_front();
      check({tag, "_cause"}, 32'(cause_id), 32'(exp_id));
    end
  endtask

  task automatic pulse_src(input logic [NSRC-1:0] v);
    irq_src = v;
    tick();
    irq_src = '0;
  endtask

  task automatic do_ack();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
  endtask

  task automatic do_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    irq_src  = '0;
    irq_mask = '0;
    ext_ack  = 1'b0;
    irq_done = 1'b0;

    // Reset hold with toggling sources
    for (int i = 0; i < 4; i++) begin
      irq_src = 4'(i * 5 + 3);
      tick();
      check("rst_irq", 32'(ext_irq), 32'd0);
      check("rst_pend", 32'(pending), 32'd0);
      check("rst_cause", 32'(cause_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    irq_src = 4'b0010;
    #2 rst_n = 1'b1;
    exp_q.push_back(1);
    tick();
    check("rel_pend", 32'(pending), 32'h2);
    check("rel_irq_early", 32'(ext_irq), 32'd0);
    tick();
    expect_req("rel");
    irq_src = '0;
    do_ack();
    check("rel_ack_irq", 32'(ext_irq), 32'd0);
    check("rel_ack_pend", 32'(pending), 32'd0);
    do_done();
    check("rel_done_busy", 32'(busy), 32'd0);

    // Single source
    exp_q.push_back(2);
    pulse_src(4'b0100);
    check("single_pend", 32'(pending), 32'h4);
    check("single_irq_early", 32'(ext_irq), 32'd0);
    tick();
    expect_req("single");
    tick(); tick(); tick();
    check("single_hold_irq", 32'(ext_irq), 32'd1);
    check("single_hold_cause", 32'(cause_id), 32'd2);
    do_ack();
    check("single_ack_irq", 32'(ext_irq), 32'd0);
    check("single_ack_pend", 32'(pending), 32'd0);
    check("single_ack_busy", 32'(busy), 32'd1);
    do_done();
    check("single_done_busy", 32'(busy), 32'd0);

    // Priority and masking
    irq_mask = 4'b0010;
    exp_q.push_back(3);
    pulse_src(4'b1010);
    check("prio_pend", 32'(pending), 32'hA);
    tick();
    expect_req("prio");
    do_ack();
    check("prio_ack_pend", 32'(pending), 32'h2);
    do_done();
    tick(); tick();
    check("prio_masked_irq", 32'(ext_irq), 32'd0);
    check("prio_masked_busy", 32'(busy), 32'd0);
    irq_mask = '0;
    exp_q.push_back(1);
    tick();
    expect_req("unmask");
    do_ack();
    do_done();

    // Set wins over clear on the acked source
    exp_q.push_back(0);
    pulse_src(4'b0001);
    tick();
    expect_req("coll");
    irq_src = 4'b0001;
    ext_ack = 1'b1;
    exp_q.push_back(0);
    tick();
    irq_src = '0;
    ext_ack = 1'b0;
    check("coll_pend", 32'(pending), 32'h1);
    check("coll_irq", 32'(ext_irq), 32'd0);
    check("coll_busy", 32'(busy), 32'd1);
    do_done();
    check("coll_idle_irq", 32'(ext_irq), 32'd0);
    tick();
    expect_req("coll2");
    do_ack();
    do_done();

    // Ignored strobes
    do_ack();
    check("ign_ack_irq", 32'(ext_irq), 32'd0);
    check("ign_ack_busy", 32'(busy), 32'd0);
    exp_q.push_back(3);
    pulse_src(4'b1000);
    tick();
    expect_req("ign");
    do_done();
    check("ign_done_irq", 32'(ext_irq), 32'd1);
    check("ign_done_cause", 32'(cause_id), 32'd3);
    do_ack();
    do_ack();
    check("ign_svc_ack_busy", 32'(busy), 32'd1);
    do_done();
    check("ign_end_busy", 32'(busy), 32'd0);

    // Reset mid-handshake
    exp_q.push_back(1);
    pulse_src(4'b0010);
    tick();
    expect_req("mid");
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_irq", 32'(ext_irq), 32'd0);
    check("mid_async_busy", 32'(busy), 32'd0);
    check("mid_async_pend", 32'(pending), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_pend", 32'(pending), 32'd0);
    check("mid_rel_busy", 32'(busy), 32'd0);
    check("mid_rel_irq", 32'(ext_irq), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
